// File: rtl/cdb_arbiter_if.sv
// Result-collection bus between the four execution units and the CDB arbiter.
// Units drive offers and the flush, and the arbiter drives the per-unit ready and the CDB.
interface cdb_arbiter_if #(
   parameter int unsigned TAG_W  = 5,
   parameter int unsigned DATA_W = 32
);
   logic              Int0_Valid;
   logic [TAG_W-1:0]  Int0_Tag;
   logic [DATA_W-1:0] Int0_Data;
   logic              Int0_Branch;
   logic              Int0_Branch_Taken;
   logic              Int0_Ready;

   logic              Int1_Valid;
   logic [TAG_W-1:0]  Int1_Tag;
   logic [DATA_W-1:0] Int1_Data;
   logic              Int1_Branch;
   logic              Int1_Branch_Taken;
   logic              Int1_Ready;

   logic              Mult_Valid;
   logic [TAG_W-1:0]  Mult_Tag;
   logic [DATA_W-1:0] Mult_Data;
   logic              Mult_Branch;
   logic              Mult_Branch_Taken;
   logic              Mult_Ready;

   logic              LS_Valid;
   logic [TAG_W-1:0]  LS_Tag;
   logic [DATA_W-1:0] LS_Data;
   logic              LS_Branch;
   logic              LS_Branch_Taken;
   logic              LS_Ready;

   logic              RB_Flush_Valid;

   logic              CDB_Valid;
   logic [TAG_W-1:0]  CDB_Tag;
   logic [DATA_W-1:0] CDB_Data;
   logic              CDB_Branch;
   logic              CDB_Branch_Taken;

   // Execution-unit / retire-bus side.
   modport master (
      output Int0_Valid, Int0_Tag, Int0_Data, Int0_Branch, Int0_Branch_Taken,
      input  Int0_Ready,
      output Int1_Valid, Int1_Tag, Int1_Data, Int1_Branch, Int1_Branch_Taken,
      input  Int1_Ready,
      output Mult_Valid, Mult_Tag, Mult_Data, Mult_Branch, Mult_Branch_Taken,
      input  Mult_Ready,
      output LS_Valid, LS_Tag, LS_Data, LS_Branch, LS_Branch_Taken,
      input  LS_Ready,
      output RB_Flush_Valid,
      input  CDB_Valid, CDB_Tag, CDB_Data, CDB_Branch, CDB_Branch_Taken
   );

   // Arbiter side.
   modport slave (
      input  Int0_Valid, Int0_Tag, Int0_Data, Int0_Branch, Int0_Branch_Taken,
      output Int0_Ready,
      input  Int1_Valid, Int1_Tag, Int1_Data, Int1_Branch, Int1_Branch_Taken,
      output Int1_Ready,
      input  Mult_Valid, Mult_Tag, Mult_Data, Mult_Branch, Mult_Branch_Taken,
      output Mult_Ready,
      input  LS_Valid, LS_Tag, LS_Data, LS_Branch, LS_Branch_Taken,
      output LS_Ready,
      input  RB_Flush_Valid,
      output CDB_Valid, CDB_Tag, CDB_Data, CDB_Branch, CDB_Branch_Taken
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Four-way round-robin CDB arbiter with one holding register per execution unit
// and a registered CDB broadcast.
module cdb_arbiter #(
   parameter int unsigned TAG_W  = 5,
   parameter int unsigned DATA_W = 32
) (
   input logic         Clk,
   input logic         Rst,
   cdb_arbiter_if.slave bus
);
   localparam int unsigned NumReq = 4;

   logic [NumReq-1:0] req_valid;
   logic [NumReq-1:0] req_branch;
   logic [NumReq-1:0] req_taken;
   logic [TAG_W-1:0]  req_tag  [NumReq];
   logic [DATA_W-1:0] req_data [NumReq];
   logic              flush;

   logic [NumReq-1:0] hold_valid;
   logic [NumReq-1:0] hold_branch;
   logic [NumReq-1:0] hold_taken;
   logic [TAG_W-1:0]  hold_tag  [NumReq];
   logic [DATA_W-1:0] hold_data [NumReq];
   logic [1:0]        rr_ptr;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              cdb_branch;
   logic              cdb_taken;

   logic [NumReq-1:0] grant;
   logic [NumReq-1:0] ready;
   logic [NumReq-1:0] accept;
   logic [1:0]        winner;
   logic [1:0]        idx;
   logic              any_grant;

   assign req_valid  = {bus.LS_Valid, bus.Mult_Valid, bus.Int1_Valid, bus.Int0_Valid};
   assign req_branch = {bus.LS_Branch, bus.Mult_Branch, bus.Int1_Branch, bus.Int0_Branch};
   assign req_taken  = {bus.LS_Branch_Taken, bus.Mult_Branch_Taken,
                        bus.Int1_Branch_Taken, bus.Int0_Branch_Taken};
   assign req_tag[0]  = bus.Int0_Tag;
   assign req_tag[1]  = bus.Int1_Tag;
   assign req_tag[2]  = bus.Mult_Tag;
   assign req_tag[3]  = bus.LS_Tag;
   assign req_data[0] = bus.Int0_Data;
   assign req_data[1] = bus.Int1_Data;
   assign req_data[2] = bus.Mult_Data;
   assign req_data[3] = bus.LS_Data;
   assign flush       = bus.RB_Flush_Valid;

   // First held entry at or after rr_ptr, wrapping; suppressed entirely during a flush.
   always_comb begin
      grant     = '0;
      winner    = '0;
      any_grant = 1'b0;
      idx       = '0;
      for (int k = 0; k < NumReq; k++) begin
         idx = rr_ptr + 2'(k);
         if (!any_grant && hold_valid[idx] && !flush) begin
            grant[idx] = 1'b1;
            winner     = idx;
            any_grant  = 1'b1;
         end
      end
   end

   // Ready is a function of holding state and flush only, never of the offer itself.
   assign ready  = (~hold_valid | grant) & {NumReq{~flush}};
   assign accept = req_valid & ready;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         hold_valid  <= '0;
         hold_branch <= '0;
         hold_taken  <= '0;
         for (int i = 0; i < NumReq; i++) begin
            hold_tag[i]  <= '0;
            hold_data[i] <= '0;
         end
         rr_ptr     <= '0;
         cdb_valid  <= 1'b0;
         cdb_tag    <= '0;
         cdb_data   <= '0;
         cdb_branch <= 1'b0;
         cdb_taken  <= 1'b0;
      end else if (flush) begin
         hold_valid <= '0;
         cdb_valid  <= 1'b0;
      end else begin
         for (int i = 0; i < NumReq; i++) begin
            // A reload on the granted port wins over the clear, so no result is lost.
            if (accept[i]) begin
               hold_valid[i]  <= 1'b1;
               hold_tag[i]    <= req_tag[i];
               hold_data[i]   <= req_data[i];
               hold_branch[i] <= req_branch[i];
               hold_taken[i]  <= req_taken[i];
            end else if (grant[i]) begin
               hold_valid[i] <= 1'b0;
            end
         end
         if (any_grant) begin
            cdb_valid  <= 1'b1;
            cdb_tag    <= hold_tag[winner];
            cdb_data   <= hold_data[winner];
            cdb_branch <= hold_branch[winner];
            cdb_taken  <= hold_taken[winner];
            rr_ptr     <= winner + 2'd1;
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

   assign bus.Int0_Ready = ready[0];
   assign bus.Int1_Ready = ready[1];
   assign bus.Mult_Ready = ready[2];
   assign bus.LS_Ready   = ready[3];

   assign bus.CDB_Valid        = cdb_valid;
   assign bus.CDB_Tag          = cdb_tag;
   assign bus.CDB_Data         = cdb_data;
   assign bus.CDB_Branch       = cdb_branch;
   assign bus.CDB_Branch_Taken = cdb_taken;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter; a queue-based result model feeds a
// scoreboard that the CDB monitor drains.
module tb_cdb_arbiter;
   localparam int unsigned TAG_W  = 5;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic              br;
      logic              bt;
   } res_t;

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

   cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus)
   );

   logic [3:0]        v, br, bt;
   logic [TAG_W-1:0]  tg [4];
   logic [DATA_W-1:0] dt [4];
   logic              flush;
   logic [3:0]        rdy;

   assign bus.Int0_Valid = v[0];  assign bus.Int0_Tag = tg[0];  assign bus.Int0_Data = dt[0];
   assign bus.Int1_Valid = v[1];  assign bus.Int1_Tag = tg[1];  assign bus.Int1_Data = dt[1];
   assign bus.Mult_Valid = v[2];  assign bus.Mult_Tag = tg[2];  assign bus.Mult_Data = dt[2];
   assign bus.LS_Valid   = v[3];  assign bus.LS_Tag   = tg[3];  assign bus.LS_Data   = dt[3];
   assign bus.Int0_Branch = br[0];  assign bus.Int0_Branch_Taken = bt[0];
   assign bus.Int1_Branch = br[1];  assign bus.Int1_Branch_Taken = bt[1];
   assign bus.Mult_Branch = br[2];  assign bus.Mult_Branch_Taken = bt[2];
   assign bus.LS_Branch   = br[3];  assign bus.LS_Branch_Taken   = bt[3];
   assign bus.RB_Flush_Valid = flush;
   assign rdy = {bus.LS_Ready, bus.Mult_Ready, bus.Int1_Ready, bus.Int0_Ready};

   // Reference model: one pending slot per unit, a pointer, and the expected broadcasts.
   bit   [3:0] pend_v;
   res_t       pend [4];
   int         rr;
   res_t       exp_q [$];
   res_t       last;
   bit         exp_valid;
   bit   [3:0] accepted;
   bit         started = 1'b0;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int first_pending();
      for (int k = 0; k < 4; k++) begin
         if (pend_v[(rr + k) % 4]) return (rr + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_step();
      int w;
      if (Rst) begin
         pend_v    = '0;
         rr        = 0;
         last      = '0;
         exp_valid = 1'b0;
         accepted  = '0;
         exp_q.delete();
         started   = 1'b1;
      end else if (flush) begin
         pend_v    = '0;
         exp_valid = 1'b0;
         accepted  = '0;
      end else begin
         w = first_pending();
         for (int i = 0; i < 4; i++) accepted[i] = v[i] && (!pend_v[i] || w == i);
         if (w >= 0) begin
            exp_q.push_back(pend[w]);
            last      = pend[w];
            exp_valid = 1'b1;
            rr        = (w + 1) % 4;
            pend_v[w] = 1'b0;
         end else begin
            exp_valid = 1'b0;
         end
         for (int i = 0; i < 4; i++) begin
            if (accepted[i]) begin
               pend_v[i] = 1'b1;
               pend[i]   = {tg[i], dt[i], br[i], bt[i]};
            end
         end
      end
   endtask

   initial forever begin
      @(posedge Clk);
      model_step();
   end

   // Monitor: sampled mid-cycle, well away from the active edge and the driver.
   initial forever begin
      res_t got, want;
      int   w;
      @(negedge Clk);
      if (started) begin
         chk("cdb_valid", 64'(bus.CDB_Valid), 64'(exp_valid));
         got = {bus.CDB_Tag, bus.CDB_Data, bus.CDB_Branch, bus.CDB_Branch_Taken};
         chk("cdb_fields", 64'(got), 64'(last));
         w = first_pending();
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("ready%0d", i), 64'(rdy[i]),
                64'(!flush && (!pend_v[i] || w == i)));
         end
         if (bus.CDB_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected", 64'(got), 64'(1) << 40);
            end else begin
               want = exp_q.pop_front();
               chk("sb_result", 64'(got), 64'(want));
            end
         end
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
      for (int i = 0; i < 4; i++) if (accepted[i]) v[i] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                       input logic b, input logic k);
      int n = 0;
      while (v[i] && n < 64) begin
         step();
         n++;
      end
      chk($sformatf("send_wait%0d", i), 64'(v[i]), 64'(0));
      tg[i] = t;
      dt[i] = d;
      br[i] = b;
      bt[i] = k;
      v[i]  = 1'b1;
   endtask

   initial begin
      Rst   = 1'b1;
      flush = 1'($urandom);
      v     = 4'($urandom);
      br    = 4'($urandom);
      bt    = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
         tg[i] = TAG_W'($urandom);
         dt[i] = $urandom;
      end
      step();
      v = 4'($urandom);
      flush = 1'($urandom);
      step();
      Rst   = 1'b0;
      v     = '0;
      br    = '0;
      bt    = '0;
      flush = 1'b0;
      idle(3);

      send(0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
      idle(4);

      for (int i = 0; i < 4; i++) send(i, TAG_W'(i + 1), $urandom, 1'b0, 1'b0);
      idle(8);

      for (int t = 10; t <= 17; t++) send(2, TAG_W'(t), $urandom, 1'b0, 1'b0);
      idle(4);

      // Park the pointer at Mult so LS wins over Int1.
      send(1, 5'd20, $urandom, 1'b0, 1'b0);
      idle(3);
      send(1, 5'd7, $urandom, 1'b1, 1'b1);
      send(3, 5'd8, $urandom, 1'b0, 1'b0);
      idle(5);

      send(0, 5'd21, $urandom, 1'b0, 1'b0);
      send(1, 5'd22, $urandom, 1'b0, 1'b0);
      send(2, 5'd23, $urandom, 1'b0, 1'b0);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle(2);
      send(0, 5'd9, $urandom, 1'b0, 1'b0);
      idle(4);

      repeat (800) begin
         for (int i = 0; i < 4; i++) begin
            if (!v[i] && $urandom_range(0, 2) != 0) begin
               tg[i] = TAG_W'($urandom);
               dt[i] = $urandom;
               br[i] = (i < 2) ? 1'($urandom) : 1'b0;
               bt[i] = br[i] & 1'($urandom);
               v[i]  = 1'b1;
            end
         end
         flush = ($urandom_range(0, 19) == 0);
         Rst   = ($urandom_range(0, 199) == 0);
         step();
      end
      Rst   = 1'b0;
      flush = 1'b0;
      v     = '0;
      idle(6);
      chk("sb_drained", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
